// File: rtl/pipeline_ctrl.sv
// Hazard and stall controller for a 5-stage pipeline: drives latch/PC enables and
// bubble flushes, tracks data-memory waits and halt, and counts stalled cycles.
module pipeline_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic        dmem_req_3,
  input  logic        dREN_out_2,
  input  logic [4:0]  wsel_out_2,
  input  logic [4:0]  rs_in_2,
  input  logic [4:0]  rt_in_2,
  input  logic        use_rt_1,
  input  logic        branch_taken_3,
  input  logic        jump_1,
  input  logic        halt_4,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        idex_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_flush,
  output logic        exmem_flush,
  output logic        halted,
  output logic [15:0] stall_count,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DWAIT = 2'd1,
    HALT  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] stall_count_q, stall_count_d;
  logic        data_freeze;
  logic        load_use;

  // A data miss freezes the whole pipe in the same cycle it is seen, before DWAIT is entered.
  assign data_freeze = (state_q == DWAIT) ||
                       ((state_q == RUN) && dmem_req_3 && !dhit);

  assign load_use = dREN_out_2 && (wsel_out_2 != 5'd0) &&
                    ((wsel_out_2 == rs_in_2) || (use_rt_1 && (wsel_out_2 == rt_in_2)));

  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (state_q != HALT && !data_freeze) begin
      if (branch_taken_3) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
      end else if (load_use) begin
        {idex_en, exmem_en, memwb_en} = 3'b111;
        idex_flush                    = 1'b1;
      end else if (!ihit) begin
        {ifid_en, idex_en, exmem_en, memwb_en} = 4'b1111;
        ifid_flush                             = 1'b1;
      end else if (jump_1) begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
        ifid_flush                                    = 1'b1;
      end else begin
        {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (halt_4) begin
      state_d = HALT;
    end else begin
      case (state_q)
        RUN:     if (dmem_req_3 && !dhit) state_d = DWAIT;
        DWAIT:   if (dhit) state_d = RUN;
        HALT:    state_d = HALT;
        default: state_d = RUN;
      endcase
    end
  end

  always_comb begin
    stall_count_d = stall_count_q;
    if ((state_q != HALT) && !pc_en && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q       <= RUN;
      stall_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign halted      = (state_q == HALT);
  assign stall_count = stall_count_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios, randomized
// traffic against a behavioural model, and stall counter saturation.
module tb_pipeline_ctrl;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        ihit = 1'b0, dhit = 1'b0, dmem_req_3 = 1'b0, dREN_out_2 = 1'b0;
  logic [4:0]  wsel_out_2 = 5'd0, rs_in_2 = 5'd0, rt_in_2 = 5'd0;
  logic        use_rt_1 = 1'b0, branch_taken_3 = 1'b0, jump_1 = 1'b0, halt_4 = 1'b0;
  logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_flush, exmem_flush, halted;
  logic [15:0] stall_count;
  logic [1:0]  state_dbg;
  logic [7:0]  ctrl_vec;

  int errors = 0;
  int checks = 0;

  // Reference model: halted/waiting flags and an integer stall tally.
  bit m_halted = 1'b0;
  bit m_wait   = 1'b0;
  int m_cnt    = 0;

  logic [7:0]  last_ctrl;
  logic        last_halted;
  logic [15:0] last_cnt;

  pipeline_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req_3(dmem_req_3),
    .dREN_out_2(dREN_out_2), .wsel_out_2(wsel_out_2), .rs_in_2(rs_in_2), .rt_in_2(rt_in_2),
    .use_rt_1(use_rt_1), .branch_taken_3(branch_taken_3), .jump_1(jump_1), .halt_4(halt_4),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .memwb_en(memwb_en), .ifid_flush(ifid_flush), .idex_flush(idex_flush),
    .exmem_flush(exmem_flush), .halted(halted), .stall_count(stall_count),
    .state_dbg(state_dbg)
  );

  assign ctrl_vec = {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                     ifid_flush, idex_flush, exmem_flush};

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {pc,ifid,idex,exmem,memwb, ifid_fl,idex_fl,exmem_fl} from the hazard rules.
  function automatic logic [7:0] model_ctrl();
    bit en[5];
    bit fl[3];
    bit lu;
    foreach (en[i]) en[i] = 1'b0;
    foreach (fl[i]) fl[i] = 1'b0;
    lu = dREN_out_2 && wsel_out_2 != 0 &&
         (wsel_out_2 == rs_in_2 || (use_rt_1 && wsel_out_2 == rt_in_2));
    if (m_halted || m_wait || (dmem_req_3 && !dhit)) begin
      // frozen or halted: everything stays low
    end else if (branch_taken_3) begin
      foreach (en[i]) en[i] = 1'b1;
      foreach (fl[i]) fl[i] = 1'b1;
    end else if (lu) begin
      en[2] = 1'b1; en[3] = 1'b1; en[4] = 1'b1; fl[1] = 1'b1;
    end else if (!ihit) begin
      for (int i = 1; i < 5; i++) en[i] = 1'b1;
      fl[0] = 1'b1;
    end else begin
      foreach (en[i]) en[i] = 1'b1;
      fl[0] = jump_1;
    end
    return {en[0], en[1], en[2], en[3], en[4], fl[0], fl[1], fl[2]};
  endfunction

  task automatic model_advance(input logic [7:0] e);
    if (!m_halted && !e[7]) m_cnt = (m_cnt >= 65535) ? 65535 : m_cnt + 1;
    if (halt_4) m_halted = 1'b1;
    else if (!m_halted) m_wait = m_wait ? !dhit : (dmem_req_3 && !dhit);
  endtask

  // One clock cycle: compare at the falling edge, advance the model, return just after rise.
  task automatic step();
    logic [7:0] e;
    @(negedge CLK);
    e = model_ctrl();
    last_ctrl   = ctrl_vec;
    last_halted = halted;
    last_cnt    = stall_count;
    chk("ctrl", ctrl_vec, e);
    chk("halted", halted, m_halted);
    chk("stall_count", stall_count, m_cnt);
    model_advance(e);
    @(posedge CLK);
    #1;
  endtask

  // Asynchronous reset pulse, entered and left just after a rising edge.
  task automatic do_reset();
    nRST = 1'b0;
    #1;
    m_halted = 1'b0;
    m_wait   = 1'b0;
    m_cnt    = 0;
    chk("rst_halted", halted, 1'b0);
    chk("rst_count", stall_count, 16'd0);
    chk("rst_ctrl", ctrl_vec, model_ctrl());
    @(posedge CLK);
    #1;
    nRST = 1'b1;
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; dmem_req_3 = 1'b0; dREN_out_2 = 1'b0;
    wsel_out_2 = 5'd0; rs_in_2 = 5'd0; rt_in_2 = 5'd0; use_rt_1 = 1'b0;
    branch_taken_3 = 1'b0; jump_1 = 1'b0; halt_4 = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    idle_inputs();
    @(posedge CLK);
    #1;
    do_reset();
    step();
    chk("idle_ctrl", last_ctrl, 8'b11111_000);

    // load-use on rs: one bubble, counter 0 -> 1
    dREN_out_2 = 1'b1; wsel_out_2 = 5'd5; rs_in_2 = 5'd5;
    step();
    chk("lu_ctrl", last_ctrl, 8'b00111_010);
    chk("lu_count", stall_count, 16'd1);
    dREN_out_2 = 1'b0;
    step();
    chk("lu_after", last_ctrl, 8'b11111_000);

    // load-use via rt only when use_rt_1 is set
    dREN_out_2 = 1'b1; wsel_out_2 = 5'd7; rs_in_2 = 5'd1; rt_in_2 = 5'd7; use_rt_1 = 1'b0;
    step();
    chk("rt_unused", last_ctrl, 8'b11111_000);
    use_rt_1 = 1'b1;
    step();
    chk("rt_used", last_ctrl, 8'b00111_010);

    // zero destination register never hazards
    idle_inputs();
    dREN_out_2 = 1'b1; wsel_out_2 = 5'd0; rs_in_2 = 5'd0;
    step();
    chk("zero_reg_ctrl", last_ctrl, 8'b11111_000);
    chk("zero_reg_count", stall_count, 16'd2);

    // data wait: three misses then a hit -> four frozen cycles
    idle_inputs();
    do_reset();
    dmem_req_3 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("dwait_ctrl", last_ctrl, 8'h00);
    end
    dhit = 1'b1;
    step();
    chk("dwait_hit_ctrl", last_ctrl, 8'h00);
    dmem_req_3 = 1'b0; dhit = 1'b0;
    step();
    chk("dwait_exit_ctrl", last_ctrl, 8'b11111_000);
    chk("dwait_count", last_cnt, 16'd4);

    // branch beats load-use and ihit=0
    branch_taken_3 = 1'b1; ihit = 1'b0;
    dREN_out_2 = 1'b1; wsel_out_2 = 5'd3; rs_in_2 = 5'd3;
    step();
    chk("branch_ctrl", last_ctrl, 8'b11111_111);
    idle_inputs();
    ihit = 1'b0;
    step();
    chk("imiss_ctrl", last_ctrl, 8'b01111_100);
    ihit = 1'b1; jump_1 = 1'b1;
    step();
    chk("jump_ctrl", last_ctrl, 8'b11111_100);

    // halt: counter frozen in HALT, reset clears it
    idle_inputs();
    do_reset();
    ihit = 1'b0;
    step();
    step();
    halt_4 = 1'b1; ihit = 1'b1;
    step();
    halt_4 = 1'b0; ihit = 1'b0;
    step();
    chk("halt_flag", last_halted, 1'b1);
    chk("halt_ctrl", last_ctrl, 8'h00);
    step();
    chk("halt_count_hold", stall_count, 16'd2);
    do_reset();
    step();
    chk("halt_reset_flag", last_halted, 1'b0);

    // halt together with a data miss: freeze now, HALT next
    idle_inputs();
    dmem_req_3 = 1'b1; halt_4 = 1'b1;
    step();
    chk("halt_freeze_ctrl", last_ctrl, 8'h00);
    halt_4 = 1'b0; dmem_req_3 = 1'b0; dhit = 1'b1;
    step();
    chk("halt_freeze_next", last_halted, 1'b1);
    chk("halt_freeze_ctrl2", last_ctrl, 8'h00);

    // reset mid-DWAIT leaves no residual freeze
    idle_inputs();
    do_reset();
    dmem_req_3 = 1'b1;
    step();
    step();
    dmem_req_3 = 1'b0;
    do_reset();
    step();
    chk("dwait_reset_ctrl", last_ctrl, 8'b11111_000);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      ihit           = ($urandom_range(0, 9) < 8);
      dhit           = ($urandom_range(0, 1) == 1);
      dmem_req_3     = ($urandom_range(0, 9) < 3);
      dREN_out_2     = ($urandom_range(0, 9) < 4);
      wsel_out_2     = 5'($urandom_range(0, 3));
      rs_in_2        = 5'($urandom_range(0, 3));
      rt_in_2        = 5'($urandom_range(0, 3));
      use_rt_1       = ($urandom_range(0, 1) == 1);
      branch_taken_3 = ($urandom_range(0, 9) == 0);
      jump_1         = ($urandom_range(0, 19) < 3);
      halt_4         = ($urandom_range(0, 49) == 0);
      if (m_halted && $urandom_range(0, 3) == 0) do_reset();
      step();
    end

    // saturation: long instruction miss
    idle_inputs();
    do_reset();
    ihit = 1'b0;
    repeat (65534) @(posedge CLK);
    #1;
    m_cnt = 65534;
    chk("sat_preload", stall_count, 16'hFFFE);
    step();
    chk("sat_reach", stall_count, 16'hFFFF);
    step();
    chk("sat_hold", stall_count, 16'hFFFF);
    step();
    chk("sat_hold2", stall_count, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
